ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle 32-bit integer divider owned by the EX stage.
- It consumes the aluop and operand fields that the ID/EX pipeline register delivers, and serves DIV/DIVU.
- EX holds the pipeline with a stall request while the divider is busy.
- The result pair {remainder, quotient} is handed to EX for the HI/LO write.

Parameters:
- WIDTH, 32, operand width. Result width is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned).
- opdata1_i  in  WIDTH  dividend (EX reg1_data).
- opdata2_i  in  WIDTH  divisor (EX reg2_data).
- start_i  in  1  EX requests a division. Held high until ready_o is seen.
- annul_i  in  1  abort the current division (flush or exception).
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}. Registered.
- ready_o  out  1  result_o valid. Registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, on rst (clk/rst as elsewhere).
  - Reset forces state FREE, cnt=0, result_o=0, ready_o=0 immediately.
  - A reset mid-operation discards the operation.
- State FREE: ready_o=0, result_o=0.
  - At an edge with start_i=1, annul_i=0 and opdata2_i==0: go to BYZERO.
  - At an edge with start_i=1, annul_i=0 and opdata2_i!=0: latch the operands and go to ON with cnt=0.
  - Operand latching, signed case: take two's-complement absolute values of negative operands. Record sign_q = sign1 XOR sign2 and sign_r = sign1.
  - Operand latching, unsigned case: operands are used raw.
  - Otherwise stay in FREE.
- State BYZERO: next edge goes to END with result_o=0 and ready_o=1. annul_i is ignored in this state.
- State ON: if annul_i=1 at an edge, go to FREE with outputs 0. Otherwise:
  - cnt<32: one restoring shift-subtract step, MSB first. Partial remainder is WIDTH+1 bits.
  - Each step compares the partial remainder against the divisor. On no-borrow, shift in 1 and replace the high half with the difference. On borrow, shift in 0.
  - Each step increments cnt.
  - cnt==32: apply signs (negate quotient if sign_q, negate remainder if sign_r, signed only). Register result_o, set ready_o=1, go to END.
- Operand changes after the start edge are ignored. start_i while in ON is ignored.
- Latency: start sampled at edge k. Steps run at edges k+1..k+32. ready_o is high after edge k+33, i.e. 34 edges including the start edge. For a zero divisor, ready_o is high after edge k+1.
- State END: ready_o=1 and result_o is held.
  - start_i=1 stays in END.
  - start_i=0 goes to FREE with ready_o=0 and result_o=0 at that edge.
  - annul_i in END is treated like start_i=0.
- Arithmetic corner cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
  - Remainder magnitude is always less than the divisor magnitude.
- EX stall contract: EX raises stallreq while start_i=1 and ready_o=0.

Decomposition:
- Shared define header additions:
  - State encodings: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady/DivResultNotReady.
  - DivStart/DivStop.
  - DoubleRegBus (63:0).
- No sub-module. The step datapath (WIDTH+1 subtractor and shift) is a combinational block inside ex_div, and the FSM is a single always block.

Test Plan:
- DIVU 100/7 (start held) -> ready_o rises exactly 34 edges after the start edge, result_o = {32'd2, 32'd14}. Dropping start_i gives ready_o=0 next edge.
- DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV/DIVU x/0 -> ready_o high after 2 edges, result_o=0. DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}. DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed at cnt=10 -> state FREE next edge, ready_o never asserted. A following DIVU 9/3 completes with {0, 3} at normal latency.
- rst asserted asynchronously mid-ON (between edges) -> ready_o=0 and result_o=0 immediately without a clock edge. After release the divider accepts a new start.
- Operands changed and start_i kept high during ON -> the result reflects the latched operands. The divider remains in END (ready_o=1) until start_i falls.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ============================================================================
// Module   : ex_div_pkg
// Purpose  : Shared state encodings and handshake constants for the EX divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef logic [63:0] double_reg_bus_t;

endpackage

`default_nettype wire

// File: rtl/ex_div_if.sv
// ============================================================================
// Module   : ex_div_if
// Purpose  : Request/result bundle between the EX stage and the divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ex_div_if
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// Module   : ex_div
// Purpose  : Multi-cycle restoring divider for DIV/DIVU, result {rem, quo}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div_if
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_END = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  div_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_rem, w_rem_nxt;
  logic [WIDTH-1:0]     r_quo, w_quo_nxt;
  logic [WIDTH-1:0]     r_dsr, w_dsr_nxt;
  logic                 r_sign_q, w_sign_q_nxt;
  logic                 r_sign_r, w_sign_r_nxt;
  logic [2*WIDTH-1:0]   r_result, w_result_nxt;
  logic                 r_ready, w_ready_nxt;

  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_borrow;
  logic                 w_neg1, w_neg2;
  logic [WIDTH-1:0]     w_abs1, w_abs2;
  logic [WIDTH-1:0]     w_rem_fin, w_quo_fin;

  // r_quo holds the dividend bits still to be consumed, MSB first, and fills
  // with quotient bits from the bottom as they are produced.
  always_comb begin
    w_shift  = {r_rem, r_quo[WIDTH-1]};
    // Partial remainder is below 2*divisor, so the top bit is the borrow.
    w_diff   = w_shift - {1'b0, r_dsr};
    w_borrow = w_diff[WIDTH];
  end

  always_comb begin
    w_neg1    = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
    w_neg2    = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
    w_abs1    = w_neg1 ? -div_if.opdata1_i : div_if.opdata1_i;
    w_abs2    = w_neg2 ? -div_if.opdata2_i : div_if.opdata2_i;
    w_rem_fin = r_sign_r ? -r_rem : r_rem;
    w_quo_fin = r_sign_q ? -r_quo : r_quo;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dsr_nxt    = r_dsr;
    w_sign_q_nxt = r_sign_q;
    w_sign_r_nxt = r_sign_r;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    case (r_state)
      DivFree: begin
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
        if (div_if.start_i == DivStart && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            w_state_nxt = DivByZero;
          end else begin
            w_state_nxt  = DivOn;
            w_cnt_nxt    = '0;
            w_rem_nxt    = '0;
            w_quo_nxt    = w_abs1;
            w_dsr_nxt    = w_abs2;
            w_sign_q_nxt = w_neg1 ^ w_neg2;
            w_sign_r_nxt = w_neg1;
          end
        end
      end

      DivByZero: begin
        w_state_nxt  = DivEnd;
        w_result_nxt = '0;
        w_ready_nxt  = DivResultReady;
      end

      DivOn: begin
        if (div_if.annul_i) begin
          w_state_nxt  = DivFree;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end else if (r_cnt != C_CNT_END) begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
          w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
          w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end else begin
          w_state_nxt  = DivEnd;
          w_result_nxt = {w_rem_fin, w_quo_fin};
          w_ready_nxt  = DivResultReady;
        end
      end

      DivEnd: begin
        if (div_if.start_i == DivStop || div_if.annul_i) begin
          w_state_nxt  = DivFree;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end
      end

      default: begin
        w_state_nxt  = DivFree;
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dsr    <= w_dsr_nxt;
      r_sign_q <= w_sign_q_nxt;
      r_sign_r <= w_sign_r_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign div_if.result_o = r_result;
  assign div_if.ready_o  = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// Module   : tb_ex_div
// Purpose  : Scoreboard bench for ex_div: latency, signed/unsigned, corners.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_div;
  import ex_div_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_div_if #(.WIDTH(W)) dif ();

  ex_div #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];

  // Reference: 64-bit host arithmetic truncates toward zero, remainder takes dividend sign.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives a request (called just after a falling edge) and counts edges until ready.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int budget, output int edges, output logic [63:0] res);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    sb_q.push_back(model(sgn, a, b));
    edges = 0;
    while (edges < budget) begin
      @(negedge clk);
      edges++;
      if (dif.ready_o === 1'b1) break;
    end
    res = dif.result_o;
  endtask

  task automatic test_reset();
    n_vec++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b result=%h expected ready=0 result=0", dif.ready_o, dif.result_o);
    end
  endtask

  task automatic test_divu_basic();
    int e; logic [63:0] r, exp;
    do_div(1'b0, 32'd100, 32'd7, 60, e, r);
    exp = sb_q.pop_front();
    n_vec++;
    if (dif.ready_o !== 1'b1 || e != 34) begin
      n_err++;
      $display("FAIL divu_latency: edges=%0d ready=%b expected edges=34 ready=1", e, dif.ready_o);
    end
    n_vec++;
    if (r !== exp || r !== {32'd2, 32'd14}) begin
      n_err++;
      $display("FAIL divu_100_7: got %h expected %h", r, exp);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL divu_release: ready=%b result=%h expected 0/0", dif.ready_o, dif.result_o);
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta[6] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FF9C, 32'd100,      32'h7FFF_FFFF, 32'hDEAD_BEEF};
    logic [31:0] tb[6] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd3,        32'h0000_1234};
    int e; logic [63:0] r, exp;
    for (int i = 0; i < 6; i++) begin
      do_div(1'b1, ta[i], tb[i], 60, e, r);
      exp = sb_q.pop_front();
      n_vec++;
      if (e != 34 || r !== exp) begin
        n_err++;
        $display("FAIL div_signed[%0d] %h/%h: got %h after %0d edges expected %h after 34",
                 i, ta[i], tb[i], r, e, exp);
      end
      dif.start_i = 1'b0;
      @(negedge clk);
    end
    // Spot checks against hand-derived values
    n_vec++;
    if (model(1'b1, 32'hFFFF_FFF9, 32'd2) !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}
        || model(1'b1, 32'd7, 32'hFFFF_FFFE) !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
      n_err++;
      $display("FAIL model_sanity: -7/2=%h 7/-2=%h", model(1'b1, 32'hFFFF_FFF9, 32'd2),
               model(1'b1, 32'd7, 32'hFFFF_FFFE));
    end
  endtask

  task automatic test_corners();
    bit          cs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ca[5] = '{32'd12345, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] cb[5] = '{32'd0,     32'd0,         32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    int          cl[5] = '{2, 2, 34, 34, 34};
    logic [63:0] ce[5] = '{64'd0, 64'd0, {32'd0, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}, {32'd5, 32'd0}};
    int e; logic [63:0] r, exp;
    for (int i = 0; i < 5; i++) begin
      do_div(cs[i], ca[i], cb[i], 60, e, r);
      exp = sb_q.pop_front();
      n_vec++;
      if (e != cl[i] || dif.ready_o !== 1'b1 || r !== exp || r !== ce[i]) begin
        n_err++;
        $display("FAIL corner[%0d] %h/%h: got %h after %0d edges expected %h after %0d",
                 i, ca[i], cb[i], r, e, ce[i], cl[i]);
      end
      dif.start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_annul();
    int e; int seen; logic [63:0] r, exp;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (11) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL annul_no_ready: ready high on %0d cycles expected 0", seen);
    end
    do_div(1'b0, 32'd9, 32'd3, 60, e, r);
    exp = sb_q.pop_front();
    n_vec++;
    if (e != 34 || r !== exp || r !== {32'd0, 32'd3}) begin
      n_err++;
      $display("FAIL annul_followup: got %h after %0d edges expected %h after 34", r, e, exp);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int e; logic [63:0] r, exp;
    // Mid-operation
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd50;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL async_rst_on: ready=%b result=%h expected 0/0", dif.ready_o, dif.result_o);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd81, 32'd9, 60, e, r);
    exp = sb_q.pop_front();
    n_vec++;
    if (e != 34 || r !== exp) begin
      n_err++;
      $display("FAIL async_rst_restart: got %h after %0d edges expected %h after 34", r, e, exp);
    end
    // In END with a nonzero result, start still held
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL async_rst_end: ready=%b result=%h expected 0/0", dif.ready_o, dif.result_o);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int e; int bad; logic [63:0] r, exp;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd10;
    dif.start_i      = 1'b1;
    sb_q.push_back(model(1'b0, 32'd1000, 32'd10));
    @(negedge clk);
    dif.signed_div_i = 1'b1;
    dif.opdata1_i    = 32'hFFFF_FFF9;
    dif.opdata2_i    = 32'd3;
    e = 1;
    while (e < 60 && dif.ready_o !== 1'b1) begin
      @(negedge clk);
      e++;
    end
    r   = dif.result_o;
    exp = sb_q.pop_front();
    n_vec++;
    if (e != 34 || r !== exp || r !== {32'd0, 32'd100}) begin
      n_err++;
      $display("FAIL operand_change: got %h after %0d edges expected %h after 34", r, e, exp);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (dif.ready_o !== 1'b1 || dif.result_o !== exp) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL end_hold: %0d cycles lost ready/result expected 0", bad);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL end_release: ready=%b result=%h expected 0/0", dif.ready_o, dif.result_o);
    end
  endtask

  initial begin
    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_divu_basic();
    test_signed();
    test_corners();
    test_annul();
    test_async_reset();
    test_operand_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
